// File: rtl/st7735_pixel_source.sv
// ---------------------------------------------------------------------------
// st7735_pixel_source
//   Test-pattern generator feeding the ST7735 SPI driver. It emits one RGB565
//   frame of WIDTH x HEIGHT pixels in raster order over a valid/ready stream.
//   The frame markers (SOF/EOL/EOF) are registered with the pixel they tag.
//
// Ports
//   SYSTEM_CLK   in   system clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   ENABLE       in   generate frames continuously while high
//   MODE[1:0]    in   0 solid, 1 colour bars, 2 checkerboard, 3 gradient
//   SOLID_COLOR  in   RGB565 colour for mode 0
//   PIXEL_READY  in   consumer accepts the presented pixel this cycle
//   PIXEL_VALID  out  PIXEL_DATA and the markers are valid
//   PIXEL_DATA   out  RGB565 pixel
//   PIXEL_SOF    out  pixel is (0,0)
//   PIXEL_EOL    out  pixel is the last one of its line
//   PIXEL_EOF    out  pixel is the last one of the frame
//   FRAME_DONE   out  one-cycle pulse after the last pixel is accepted
//   BUSY         out  generator is inside a frame
//   FRAME_COUNT  out  completed frames, wraps at 256
// ---------------------------------------------------------------------------
module st7735_pixel_source #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int CHECK_LOG2 = 3
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [1:0]  MODE,
  input  logic [15:0] SOLID_COLOR,
  input  logic        PIXEL_READY,
  output logic        PIXEL_VALID,
  output logic [15:0] PIXEL_DATA,
  output logic        PIXEL_SOF,
  output logic        PIXEL_EOL,
  output logic        PIXEL_EOF,
  output logic        FRAME_DONE,
  output logic        BUSY,
  output logic [7:0]  FRAME_COUNT
);

  localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BARW = WIDTH / 8;
  localparam int SW   = (BARW > 1) ? $clog2(BARW) : 1;
  // Pattern views of x/y: wide enough for the gradient fields and the
  // checker bit, whatever the counter widths turn out to be.
  localparam int GXW  = (CHECK_LOG2 + 1 > 5) ? CHECK_LOG2 + 1 : 5;
  localparam int GYW  = (CHECK_LOG2 + 1 > 6) ? CHECK_LOG2 + 1 : 6;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(BARW - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [SW-1:0] sub_q, sub_d;     // position inside the current bar
  logic [2:0]    bar_q, bar_d;     // bar index, avoids dividing x
  logic [1:0]    mode_q, mode_d;   // frame-latched pattern select
  logic [15:0]   solid_q, solid_d;
  logic [4:0]    fc5_q, fc5_d;     // frame count seen at frame start
  logic [7:0]    fcnt_q, fcnt_d;
  logic          valid_q, valid_d;
  logic [15:0]   data_q, data_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          xfer, at_last, frame_end, start, advance;
  logic [GXW-1:0] gx;
  logic [GYW-1:0] gy;

  assign xfer      = valid_q & PIXEL_READY;
  assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign frame_end = (state_q == S_RUN) && xfer && at_last;
  // A frame starts either from IDLE or seamlessly after the previous EOF.
  assign start     = ((state_q == S_IDLE) && ENABLE) || (frame_end && ENABLE);
  assign advance   = (state_q == S_RUN) && xfer && !at_last;

  function automatic logic [15:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // State register
  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: ENABLE only matters at a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ENABLE) state_d = S_RUN;
      S_RUN:   if (frame_end && !ENABLE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Position counters and frame-latched settings
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    sub_d   = sub_q;
    bar_d   = bar_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    fc5_d   = fc5_q;
    fcnt_d  = fcnt_q + {7'd0, frame_end};
    if (start) begin
      x_d     = '0;
      y_d     = '0;
      sub_d   = '0;
      bar_d   = '0;
      mode_d  = MODE;
      solid_d = SOLID_COLOR;
      // Post-increment count, so a back-to-back frame sees its own number.
      fc5_d   = fcnt_d[4:0];
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_d   = '0;
        y_d   = y_q + 1'b1;
        sub_d = '0;
        bar_d = '0;
      end else begin
        x_d = x_q + 1'b1;
        if (sub_q == S_LAST) begin
          sub_d = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
    end
  end

  assign gx = GXW'(x_d);
  assign gy = GYW'(y_d);

  // Output logic: the next pixel and its markers are built from the next
  // counter values so everything lands in the output registers together.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    done_d  = frame_end;
    busy_d  = (state_d == S_RUN);
    if (start || advance) begin
      valid_d = 1'b1;
      sof_d   = (x_d == '0) && (y_d == '0);
      eol_d   = (x_d == X_LAST);
      eof_d   = (x_d == X_LAST) && (y_d == Y_LAST);
      case (mode_d)
        2'd0:    data_d = solid_d;
        2'd1:    data_d = bar_color(bar_d);
        2'd2:    data_d = (gx[CHECK_LOG2] ^ gy[CHECK_LOG2]) ? 16'h0000 : 16'hFFFF;
        default: data_d = {gx[4:0], gy[5:0], fc5_d};
      endcase
    end else if (frame_end) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      eof_d   = 1'b0;
    end
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q     <= '0;
      y_q     <= '0;
      sub_q   <= '0;
      bar_q   <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      fc5_q   <= '0;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sub_q   <= sub_d;
      bar_q   <= bar_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      fc5_q   <= fc5_d;
      fcnt_q  <= fcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign PIXEL_VALID = valid_q;
  assign PIXEL_DATA  = data_q;
  assign PIXEL_SOF   = sof_q;
  assign PIXEL_EOL   = eol_q;
  assign PIXEL_EOF   = eof_q;
  assign FRAME_DONE  = done_q;
  assign BUSY        = busy_q;
  assign FRAME_COUNT = fcnt_q;

endmodule

// File: tb/tb_st7735_pixel_source.sv
// ---------------------------------------------------------------------------
// tb_st7735_pixel_source
//   Scenario bench for st7735_pixel_source on a reduced 48x40 frame. Each
//   transferred pixel is recorded and compared against a raster model that
//   derives colour and markers from the frame index and pixel coordinates.
// ---------------------------------------------------------------------------
module tb_st7735_pixel_source;
  localparam int W  = 48;
  localparam int H  = 40;
  localparam int CL = 3;
  localparam int N  = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid = 16'h0000;
  logic        rdy = 1'b0;
  logic        PIXEL_VALID, PIXEL_SOF, PIXEL_EOL, PIXEL_EOF, FRAME_DONE, BUSY;
  logic [15:0] PIXEL_DATA;
  logic [7:0]  FRAME_COUNT;

  st7735_pixel_source #(.WIDTH(W), .HEIGHT(H), .CHECK_LOG2(CL)) dut (
    .SYSTEM_CLK(clk), .RESET_N(rst_n), .ENABLE(en), .MODE(mode),
    .SOLID_COLOR(solid), .PIXEL_READY(rdy), .PIXEL_VALID(PIXEL_VALID),
    .PIXEL_DATA(PIXEL_DATA), .PIXEL_SOF(PIXEL_SOF), .PIXEL_EOL(PIXEL_EOL),
    .PIXEL_EOF(PIXEL_EOF), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY),
    .FRAME_COUNT(FRAME_COUNT));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] q_data[$];
  bit          q_sof[$], q_eol[$], q_eof[$];
  int stall_err, fd_cnt, gap_cnt, first_bad;
  bit tmo;

  // Reference colour of pixel (x,y) for a given pattern.
  function automatic logic [15:0] ref_pix(int m, logic [15:0] s, int x, int y, int fc);
    int bi;
    case (m)
      0: return s;
      1: begin
        bi = x / (W / 8);
        case (bi)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2: return ((((x >> CL) ^ (y >> CL)) & 1) == 0) ? 16'hFFFF : 16'h0000;
      default: return {5'(x), 6'(y), 5'(fc)};
    endcase
  endfunction

  // Frames before swf use pattern m0, later ones m1; frame f started at count fc0+f.
  function automatic int data_errs(int m0, int m1, int swf, logic [15:0] s, int fc0);
    int e, f, p, m;
    e = 0;
    first_bad = -1;
    for (int t = 0; t < q_data.size(); t++) begin
      f = t / N;
      p = t % N;
      m = (f < swf) ? m0 : m1;
      if (q_data[t] !== ref_pix(m, s, p % W, p / W, fc0 + f)) begin
        e++;
        if (first_bad < 0) first_bad = t;
      end
    end
    return e;
  endfunction

  function automatic int marker_errs();
    int e, p;
    e = 0;
    for (int t = 0; t < q_data.size(); t++) begin
      p = t % N;
      if (q_sof[t] != (p == 0) || q_eol[t] != ((p % W) == W - 1) || q_eof[t] != (p == N - 1))
        e++;
    end
    return e;
  endfunction

  // Drives READY (pct % of cycles) until n transfers were recorded.
  // act_kind 1: MODE <= act_val at transfer act_at; 2: ENABLE <= 0 there.
  task automatic run_xfers(input int n, input int pct, input int act_at,
                           input int act_kind, input int act_val);
    int cyc;
    logic pv, pr, ps, pe, pf;
    logic [15:0] pd;
    cyc = 0; pv = 0; pr = 0; ps = 0; pe = 0; pf = 0; pd = '0;
    q_data.delete(); q_sof.delete(); q_eol.delete(); q_eof.delete();
    stall_err = 0; fd_cnt = 0; gap_cnt = 0; tmo = 0;
    while (q_data.size() < n) begin
      @(negedge clk);
      if (FRAME_DONE) fd_cnt++;
      if (!PIXEL_VALID) gap_cnt++;
      if (pv && !pr && (!PIXEL_VALID || PIXEL_DATA !== pd || PIXEL_SOF !== ps ||
                        PIXEL_EOL !== pe || PIXEL_EOF !== pf))
        stall_err++;
      if (q_data.size() == act_at) begin
        if (act_kind == 1) mode = act_val[1:0];
        if (act_kind == 2) en = 1'b0;
      end
      rdy = ($urandom_range(99) < pct);
      if (PIXEL_VALID && rdy) begin
        q_data.push_back(PIXEL_DATA);
        q_sof.push_back(PIXEL_SOF);
        q_eol.push_back(PIXEL_EOL);
        q_eof.push_back(PIXEL_EOF);
      end
      pv = PIXEL_VALID; pr = rdy; pd = PIXEL_DATA;
      ps = PIXEL_SOF; pe = PIXEL_EOL; pf = PIXEL_EOF;
      cyc++;
      if (cyc > n * 4 + 100) begin
        tmo = 1;
        break;
      end
    end
    @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    if (FRAME_DONE) fd_cnt++;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({PIXEL_VALID, PIXEL_SOF, PIXEL_EOL, PIXEL_EOF, FRAME_DONE, BUSY} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000000",
               {PIXEL_VALID, PIXEL_SOF, PIXEL_EOL, PIXEL_EOF, FRAME_DONE, BUSY});
    end
    n_cmp++;
    if (PIXEL_DATA !== 16'h0 || FRAME_COUNT !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%0d expected 0000/0", PIXEL_DATA, FRAME_COUNT);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_solid_stop();
    int e;
    @(negedge clk);
    mode = 2'd0; solid = 16'hF800; en = 1'b1;
    #1;
    n_cmp++;
    if (PIXEL_VALID !== 1'b0) begin
      n_bad++; $display("FAIL solid_pre_valid: got %b expected 0", PIXEL_VALID);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (PIXEL_VALID !== 1'b1 || PIXEL_SOF !== 1'b1 || BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL solid_latency: got v=%b sof=%b busy=%b expected 1 1 1",
               PIXEL_VALID, PIXEL_SOF, BUSY);
    end
    run_xfers(N, 100, 100, 2, 0);
    n_cmp++;
    if (tmo || q_data.size() != N) begin
      n_bad++; $display("FAIL solid_count: got %0d expected %0d", q_data.size(), N);
    end
    e = data_errs(0, 0, 1, 16'hF800, 0);
    n_cmp++;
    if (e != 0) begin
      n_bad++; $display("FAIL solid_data: got %0d bad (first %0d) expected 0", e, first_bad);
    end
    e = marker_errs();
    n_cmp++;
    if (e != 0) begin
      n_bad++; $display("FAIL solid_markers: got %0d bad expected 0", e);
    end
    n_cmp++;
    if (fd_cnt != 1 || FRAME_COUNT !== 8'd1) begin
      n_bad++; $display("FAIL solid_done: got pulses=%0d count=%0d expected 1 1", fd_cnt, FRAME_COUNT);
    end
    n_cmp++;
    if (PIXEL_VALID !== 1'b0 || BUSY !== 1'b0) begin
      n_bad++; $display("FAIL solid_stop: got v=%b busy=%b expected 0 0", PIXEL_VALID, BUSY);
    end
  endtask

  task automatic test_bars();
    int e;
    @(negedge clk);
    mode = 2'd1; en = 1'b1;
    run_xfers(N, 100, 0, 2, 0);
    e = data_errs(1, 1, 1, 16'h0, 0);
    n_cmp++;
    if (tmo || q_data.size() != N || e != 0) begin
      n_bad++; $display("FAIL bars_data: got %0d bad of %0d expected 0", e, q_data.size());
    end
    n_cmp++;
    if (q_data.size() == N && (q_data[0] !== 16'hFFFF || q_data[W/8] !== 16'hFFE0 ||
        q_data[W-1] !== 16'h0000 || q_data[(H-1)*W + 2*(W/8)] !== 16'h07FF)) begin
      n_bad++;
      $display("FAIL bars_points: got %h %h %h %h expected ffff ffe0 0000 07ff",
               q_data[0], q_data[W/8], q_data[W-1], q_data[(H-1)*W + 2*(W/8)]);
    end
    n_cmp++;
    if (fd_cnt != 1 || FRAME_COUNT !== 8'd2 || PIXEL_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL bars_end: got pulses=%0d count=%0d v=%b expected 1 2 0",
               fd_cnt, FRAME_COUNT, PIXEL_VALID);
    end
  endtask

  task automatic test_checker_stall();
    int e;
    @(negedge clk);
    mode = 2'd2; en = 1'b1;
    run_xfers(N, 50, 0, 2, 0);
    n_cmp++;
    if (stall_err != 0) begin
      n_bad++; $display("FAIL checker_stall: got %0d unstable cycles expected 0", stall_err);
    end
    n_cmp++;
    if (tmo || q_data.size() != N) begin
      n_bad++; $display("FAIL checker_count: got %0d expected %0d", q_data.size(), N);
    end
    e = data_errs(2, 2, 1, 16'h0, 0) + marker_errs();
    n_cmp++;
    if (e != 0) begin
      n_bad++; $display("FAIL checker_data: got %0d bad expected 0", e);
    end
    n_cmp++;
    if (q_data.size() == N && (q_data[8] !== 16'h0000 || q_data[8*W+8] !== 16'hFFFF ||
        q_data[0] !== 16'hFFFF)) begin
      n_bad++;
      $display("FAIL checker_points: got %h %h %h expected 0000 ffff ffff",
               q_data[8], q_data[8*W+8], q_data[0]);
    end
    n_cmp++;
    if (fd_cnt != 1 || FRAME_COUNT !== 8'd3) begin
      n_bad++; $display("FAIL checker_end: got pulses=%0d count=%0d expected 1 3", fd_cnt, FRAME_COUNT);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [15:0] s;
    s = 16'($urandom);
    @(negedge clk);
    mode = 2'd0; solid = s; en = 1'b1;
    run_xfers(3 * N, 100, 500, 1, 3);
    n_cmp++;
    if (tmo || q_data.size() != 3 * N || gap_cnt != 0) begin
      n_bad++; $display("FAIL b2b_stream: got %0d xfers gaps=%0d expected %0d 0",
                        q_data.size(), gap_cnt, 3 * N);
    end
    e = data_errs(0, 3, 1, s, 3);
    n_cmp++;
    if (e != 0) begin
      n_bad++; $display("FAIL b2b_data: got %0d bad (first %0d) expected 0", e, first_bad);
    end
    e = marker_errs();
    n_cmp++;
    if (e != 0) begin
      n_bad++; $display("FAIL b2b_markers: got %0d bad expected 0", e);
    end
    n_cmp++;
    if (q_data.size() == 3 * N && q_data[N + 2*W + 3] !== {5'd3, 6'd2, 5'd4}) begin
      n_bad++; $display("FAIL b2b_grad_pt: got %h expected %h", q_data[N + 2*W + 3], {5'd3, 6'd2, 5'd4});
    end
    n_cmp++;
    if (fd_cnt != 3 || FRAME_COUNT !== 8'd6 || PIXEL_VALID !== 1'b1 || PIXEL_SOF !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_end: got pulses=%0d count=%0d v=%b sof=%b expected 3 6 1 1",
               fd_cnt, FRAME_COUNT, PIXEL_VALID, PIXEL_SOF);
    end
  endtask

  task automatic test_reset_midframe();
    run_xfers(700, 100, -1, 0, 0);
    n_cmp++;
    if (tmo || q_sof.size() == 0 || q_sof[0] !== 1'b1 || BUSY !== 1'b1) begin
      n_bad++; $display("FAIL midreset_pre: got %0d xfers busy=%b expected 700 1", q_sof.size(), BUSY);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({PIXEL_VALID, PIXEL_SOF, PIXEL_EOL, PIXEL_EOF, BUSY} !== 5'b0 ||
        PIXEL_DATA !== 16'h0 || FRAME_COUNT !== 8'h0) begin
      n_bad++;
      $display("FAIL midreset_async: got v=%b busy=%b data=%h count=%0d expected all 0",
               PIXEL_VALID, BUSY, PIXEL_DATA, FRAME_COUNT);
    end
    mode = 2'd0; solid = 16'h1234; en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (PIXEL_VALID !== 1'b1 || PIXEL_SOF !== 1'b1 || PIXEL_DATA !== 16'h1234) begin
      n_bad++;
      $display("FAIL midreset_restart: got v=%b sof=%b data=%h expected 1 1 1234",
               PIXEL_VALID, PIXEL_SOF, PIXEL_DATA);
    end
    en = 1'b0;
    run_xfers(1, 100, -1, 0, 0);
    n_cmp++;
    if (q_data.size() != 1 || q_data[0] !== 16'h1234 || q_sof[0] !== 1'b1 || FRAME_COUNT !== 8'd0) begin
      n_bad++;
      $display("FAIL midreset_first: got %0d xfers count=%0d expected 1 xfer of 1234, count 0",
               q_data.size(), FRAME_COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_solid_stop();
    test_bars();
    test_checker_stall();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/st7735_pixel_source.md
Name: st7735_pixel_source

Overview:
- Upstream pixel generator for the ST7735 SPI driver.
- Produces one RGB565 frame of WIDTH x HEIGHT pixels in raster order: row 0 first, left to right within each row.
- Pixels leave over a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers.
- Offers four test patterns (solid, colour bars, checkerboard, animated gradient). The driver consumes one pixel per 16 SPI bits.

Parameters:
- WIDTH, 160, pixels per line; must be a multiple of 8.
- HEIGHT, 120, lines per frame.
- CHECK_LOG2, 3, checkerboard square size is 2**CHECK_LOG2 pixels.

Ports:
- SYSTEM_CLK  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  level; high = generate frames continuously.
- MODE  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 gradient.
- SOLID_COLOR  in  16  RGB565 colour for mode 0.
- PIXEL_READY  in  1  consumer accepts the pixel this cycle.
- PIXEL_VALID  out  1  PIXEL_DATA and the marker outputs are valid.
- PIXEL_DATA  out  16  RGB565 pixel.
- PIXEL_SOF  out  1  current pixel is (x=0, y=0).
- PIXEL_EOL  out  1  current pixel is x = WIDTH-1.
- PIXEL_EOF  out  1  current pixel is (WIDTH-1, HEIGHT-1).
- FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- BUSY  out  1  high while in RUN.
- FRAME_COUNT  out  8  completed frames; wraps 255 -> 0.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - All outputs 0, state IDLE, x = y = 0, FRAME_COUNT = 0.
  - Applies immediately, including mid-frame. After release, no partial frame resumes; generation restarts at (0,0).
- All outputs are registered.
- A transfer occurs on a rising edge where PIXEL_VALID and PIXEL_READY are both high.
- While PIXEL_VALID is high and PIXEL_READY is low: PIXEL_DATA, the markers and x/y hold stable.
- PIXEL_VALID never drops without a transfer, except on reset.
- States:
  - IDLE: VALID = 0, BUSY = 0. On an edge with ENABLE = 1:
    - latch MODE and SOLID_COLOR into frame registers;
    - load pixel (0,0); VALID = 1, SOF = 1; go to RUN.
    - Latency: VALID is high one cycle after ENABLE is first sampled high.
  - RUN: on each transfer, advance x; at x = WIDTH-1 wrap x to 0 and increment y.
  - Transfer of pixel (WIDTH-1, HEIGHT-1):
    - FRAME_DONE = 1 for the next cycle only; FRAME_COUNT increments on the same edge.
    - If ENABLE = 1: re-latch MODE/SOLID_COLOR and present the next frame's (0,0) pixel on the same edge. No bubble; VALID stays 1.
    - If ENABLE = 0: VALID = 0, go to IDLE.
- ENABLE deasserted mid-frame: the current frame completes. ENABLE is sampled only at frame boundaries.
- MODE and SOLID_COLOR changes mid-frame are ignored until the next frame start.
- Patterns (frame-latched mode):
  - Mode 0: PIXEL_DATA = latched SOLID_COLOR.
  - Mode 1: 8 vertical bars, each WIDTH/8 wide.
    - Colours left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
    - Bar index comes from a sub-counter (0..WIDTH/8-1) plus a 3-bit bar counter, both cleared at line start. No dividers.
  - Mode 2: PIXEL_DATA = FFFF if x[CHECK_LOG2] XOR y[CHECK_LOG2] = 0, else 0000.
  - Mode 3: PIXEL_DATA = {x[4:0], y[5:0], FRAME_COUNT[4:0]}, with FRAME_COUNT as of frame start.
- Markers:
  - SOF, EOL and EOF are registered alongside PIXEL_DATA and qualify the same pixel.
  - For WIDTH = 1 or HEIGHT = 1 they may coincide; all applicable markers assert together.
- x counter width is clog2(WIDTH); y counter width is clog2(HEIGHT). No pixel index beyond x/y is kept.
- Simultaneous events:
  - FRAME_DONE pulse and the first pixel of the next frame may overlap.
  - Reset overrides everything.

Test Plan:
- Reset, ENABLE = 1, MODE = 0, SOLID_COLOR = F800, PIXEL_READY = 1 -> VALID rises 1 cycle after ENABLE; 19200 transfers all F800; SOF on transfer 1, EOL on every 160th, EOF on 19200; FRAME_DONE pulses once; FRAME_COUNT = 1.
- MODE = 1, READY = 1 -> line 0 pixels 0..19 = FFFF, 20..39 = FFE0, ..., 140..159 = 0000; identical on line 119.
- MODE = 2, READY toggled randomly 50% -> data/markers stable during stalls; pixel (8,0) = 0000, (8,8) = FFFF, (0,0) = FFFF; exactly 19200 transfers per frame.
- ENABLE held 1 for 3 frames, MODE switched 0 -> 3 at pixel 5000 -> frame 1 stays solid; frame 2 gradient with pixel (3,2) = {00011, 000010, 00001}; no VALID gap between frames; FRAME_COUNT = 3.
- ENABLE dropped at pixel 100 -> frame completes to EOF, then VALID = 0, BUSY = 0.
- RESET_N pulsed low at pixel 7000 -> outputs 0 asynchronously; after release with ENABLE = 1, next transfer is (0,0) with SOF = 1; FRAME_COUNT = 0.
